// File: rtl/hello_pkg.sv
// Shared types and constants for the HELLO seven-segment sequencing path.
package hello_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Character indices in display order; blank closes each word.
    localparam logic [2:0] IDX_BLANK = 3'd0;
    localparam logic [2:0] IDX_H     = 3'd1;
    localparam logic [2:0] IDX_E     = 3'd2;
    localparam logic [2:0] IDX_L1    = 3'd3;
    localparam logic [2:0] IDX_L2    = 3'd4;
    localparam logic [2:0] IDX_O     = 3'd5;

    // Active-low segment codes.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_O     = 8'hC0;

    // Step to the following character; O wraps to the trailing blank.
    function automatic logic [2:0] next_idx(input logic [2:0] cur);
        return (cur == IDX_O) ? IDX_BLANK : cur + 3'd1;
    endfunction

endpackage

// File: rtl/hello_seq_ctrl_if.sv
// Requester-side handshake and display outputs of the HELLO controller.
interface hello_seq_ctrl_if;
    logic       start;
    logic       pause;
    logic       stop;
    logic [7:0] seg;
    logic [2:0] idx;
    logic       busy;
    logic       done;

    // Board control logic drives the buttons and watches status.
    modport master (output start, pause, stop, input seg, idx, busy, done);
    // The controller consumes the buttons and produces status/display.
    modport slave  (input start, pause, stop, output seg, idx, busy, done);
endinterface

// File: rtl/hello_seg_rom.sv
// Combinational character-index to active-low segment decoder.
module hello_seg_rom
    import hello_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] seg
);

    // Decode the index; unused codes 6 and 7 show blank.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        seg = SEG_BLANK;
        case (idx)
            IDX_H:  seg = SEG_H;
            IDX_E:  seg = SEG_E;
            IDX_L1: seg = SEG_L;
            IDX_L2: seg = SEG_L;
            IDX_O:  seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hello_seq_ctrl.sv
// Start/pause/stop playback sequencer for the HELLO display: each character
// dwells DIV cycles and the word repeats REPS times before a done pulse.
module hello_seq_ctrl
    import hello_pkg::*;
#(
    parameter int unsigned DIV  = 4,
    parameter int unsigned REPS = 2
) (
    input  logic            ck,
    input  logic            rs,
    hello_seq_ctrl_if.slave bus
);

    localparam int unsigned   DW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [7:0]    REP_LAST   = 8'(REPS - 1);

    state_t        state;
    logic [DW-1:0] dwell;
    logic [7:0]    rep;
    logic [2:0]    idx_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    seg_w;

    // Segment pattern follows the registered index with no extra latency.
    hello_seg_rom u_rom (
        .idx (idx_q),
        .seg (seg_w)
    );

    assign bus.seg  = seg_w;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Single-process FSM with registered outputs; in RUN stop beats pause beats advance.
    always_ff @(posedge ck) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rs) begin
            state  <= IDLE;
            idx_q  <= IDX_BLANK;
            dwell  <= '0;
            rep    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        idx_q  <= IDX_H;
                        dwell  <= '0;
                        rep    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        idx_q  <= IDX_BLANK;
                        dwell  <= '0;
                        rep    <= '0;
                        busy_q <= 1'b0;
                    end else if (!bus.pause) begin
                        if (dwell == DWELL_LAST) begin
                            dwell <= '0;
                            if (idx_q == IDX_BLANK) begin
                                if (rep == REP_LAST) begin
                                    state  <= DONE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    rep   <= rep + 8'd1;
                                    idx_q <= IDX_H;
                                end
                            end else begin
                                idx_q <= next_idx(idx_q);
                            end
                        end else begin
                            dwell <= dwell + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    rep    <= '0;
                end
                default: begin
                    state  <= IDLE;
                    idx_q  <= IDX_BLANK;
                    dwell  <= '0;
                    rep    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hello_seq_ctrl.sv
// Self-checking bench for hello_seq_ctrl: directed scenarios plus random
// button activity, all compared against a position-based playback model.
module tb_hello_seq_ctrl;

    localparam int DIV   = 4;
    localparam int REPS  = 2;
    localparam int TOTAL = REPS * 6 * DIV;

    logic ck;
    logic rs;

    hello_seq_ctrl_if bus ();

    hello_seq_ctrl #(.DIV(DIV), .REPS(REPS)) dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0=idle 1=run 2=done; pos = cycles of playback advanced so far.
    int m_mode;
    int m_pos;

    logic [7:0] seg_tab [8];

    // Per-scenario observation counters.
    int busy_seen;
    int done_seen;
    int e_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Character shown at playback position p: H,E,L,L,O,blank each DIV cycles.
    function automatic int model_idx();
        if (m_mode != 1) return 0;
        return ((m_pos / DIV) % 6 + 1) % 6;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic pa, input logic st);
        if (r) begin
            m_mode = 0;
            m_pos  = 0;
        end else begin
            case (m_mode)
                0: if (s) begin m_mode = 1; m_pos = 0; end
                1: begin
                    if (st) begin
                        m_mode = 0;
                        m_pos  = 0;
                    end else if (!pa) begin
                        if (m_pos == TOTAL - 1) begin
                            m_mode = 2;
                            m_pos  = 0;
                        end else begin
                            m_pos++;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    // Apply one cycle of inputs, advance model, then compare away from the edge.
    task automatic tick(input logic r, input logic s, input logic pa, input logic st);
        int ei;
        rs        = r;
        bus.start = s;
        bus.pause = pa;
        bus.stop  = st;
        @(posedge ck);
        model_step(r, s, pa, st);
        @(negedge ck);
        ei = model_idx();
        check("idx",  32'(bus.idx),  32'(ei));
        check("seg",  32'(bus.seg),  32'(seg_tab[ei]));
        check("busy", 32'(bus.busy), 32'(m_mode == 1));
        check("done", 32'(bus.done), 32'(m_mode == 2));
        if (bus.busy) busy_seen++;
        if (bus.done) done_seen++;
        if (bus.seg == 8'h86) e_seen++;
    endtask

    task automatic clear_counts();
        busy_seen = 0;
        done_seen = 0;
        e_seen    = 0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        seg_tab = '{8'hFF, 8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hFF};
        m_mode = 0;
        m_pos  = 0;
        clear_counts();

        // Reset for two edges, then reset together with start stays idle.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_seg", 32'(bus.seg), 32'h0000_00FF);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_start_busy", 32'(bus.busy), 32'd0);

        // Plain run: 48 busy cycles, one done pulse.
        clear_counts();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(TOTAL + 6);
        check("run_busy_len", 32'(busy_seen), 32'(TOTAL));
        check("run_done_cnt", 32'(done_seen), 32'd1);
        check("run_e_len",    32'(e_seen),    32'(2 * DIV));

        // Pause three cycles while E is shown.
        clear_counts();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(DIV + 1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        idle_ticks(TOTAL + 6);
        check("pause_busy_len", 32'(busy_seen), 32'(TOTAL + 3));
        check("pause_done_cnt", 32'(done_seen), 32'd1);
        check("pause_e_len",    32'(e_seen),    32'(2 * DIV + 3));

        // Stop while L is shown: no done, later start replays from H.
        clear_counts();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(2 * DIV);
        check("stop_pre_seg", 32'(bus.seg), 32'h0000_00C7);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("stop_busy", 32'(bus.busy), 32'd0);
        idle_ticks(TOTAL);
        check("stop_no_done", 32'(done_seen), 32'd0);
        clear_counts();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("replay_idx", 32'(bus.idx), 32'd1);
        idle_ticks(TOTAL + 4);
        check("replay_busy_len", 32'(busy_seen), 32'(TOTAL));

        // Reset during O of the second repetition, then a full run.
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(6 * DIV + 4 * DIV);
        check("rst_mid_pre_seg", 32'(bus.seg), 32'h0000_00C0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_mid_idx", 32'(bus.idx), 32'd0);
        clear_counts();
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        idle_ticks(TOTAL + 4);
        check("rst_mid_busy_len", 32'(busy_seen), 32'(TOTAL));
        check("rst_mid_done_cnt", 32'(done_seen), 32'd1);

        // Start held high: automatic restart after done plus one idle cycle.
        clear_counts();
        for (int i = 0; i < TOTAL + 6; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_done_cnt", 32'(done_seen), 32'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_pause_busy", 32'(bus.busy), 32'd0);
        idle_ticks(3);

        // Random button activity.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(40) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
